// File: rtl/ucsbece154b_branch_resolve.sv
// ucsbece154b_branch_resolve
// Matches fetch-time predictions, held in a small in-order queue, against
// execute-stage outcomes. It produces the BTB/PHT/GHR update pulses and the
// mispredict redirect, and flushes the queue for one cycle after a mispredict.
// Optional feature: define BRANCH_STATS_EN to add the branch_count_o and
// mispredict_count_o statistics outputs.
module ucsbece154b_branch_resolve #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic                               f_valid_i,
    input  logic [31:0]                        f_pc_i,
    input  logic                               f_taken_i,
    input  logic [31:0]                        f_target_i,
    input  logic [NUM_GHR_BITS-1:0]            f_phtaddr_i,
    output logic                               f_ready_o,
    input  logic                               e_valid_i,
    input  logic [6:0]                         e_op_i,
    input  logic [31:0]                        e_pc_i,
    input  logic                               e_taken_i,
    input  logic [31:0]                        e_target_i,
    output logic                               BTBwe_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic                               PHTwe_o,
    output logic                               PHTincrement_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               GHRreset_o,
    output logic                               mispredict_o,
    output logic [31:0]                        redirect_pc_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]                        branch_count_o,
    output logic [31:0]                        mispredict_count_o
`endif
);

    localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);
    localparam int PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    // RISC-V control-flow opcodes
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state_r;
    state_t state_n_s;

    // Prediction record queue
    logic [31:0]             q_pc_r     [QUEUE_DEPTH];
    logic                    q_taken_r  [QUEUE_DEPTH];
    logic [31:0]             q_target_r [QUEUE_DEPTH];
    logic [NUM_GHR_BITS-1:0] q_pht_r    [QUEUE_DEPTH];
    logic [PTR_W-1:0]        wptr_r;
    logic [PTR_W-1:0]        rptr_r;
    logic [CNT_W-1:0]        count_r;

    logic                    idle_s;
    logic                    empty_s;
    logic                    full_s;
    logic                    head_hit_s;
    logic [31:0]             pc_plus4_s;
    logic                    pred_taken_s;
    logic [31:0]             pred_target_s;
    logic [NUM_GHR_BITS-1:0] pred_pht_s;
    logic                    is_branch_s;
    logic                    is_ctrl_s;
    logic                    e_accept_s;
    logic                    target_miss_s;
    logic                    mispredict_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    pht_we_s;
    logic                    btb_we_s;

    // Select the prediction to compare against: queue head on a pc match, else not-taken fall-through
    always_comb begin
        idle_s     = (state_r == IDLE);
        empty_s    = (count_r == {CNT_W{1'b0}});
        full_s     = (count_r == CNT_FULL);
        pc_plus4_s = e_pc_i + 32'd4;
        head_hit_s = !empty_s && (q_pc_r[rptr_r] == e_pc_i);
        if (head_hit_s) begin
            pred_taken_s  = q_taken_r[rptr_r];
            pred_target_s = q_target_r[rptr_r];
            pred_pht_s    = q_pht_r[rptr_r];
        end else begin
            pred_taken_s  = 1'b0;
            pred_target_s = pc_plus4_s;
            pred_pht_s    = {NUM_GHR_BITS{1'b0}};
        end
    end

    // Classify the resolved op and decide mispredict, queue movement and table updates
    always_comb begin
        is_branch_s   = (e_op_i == OP_BRANCH);
        is_ctrl_s     = is_branch_s || (e_op_i == OP_JAL) || (e_op_i == OP_JALR);
        e_accept_s    = e_valid_i && idle_s;
        target_miss_s = e_taken_i && (pred_target_s != e_target_i);
        if (!e_accept_s) begin
            mispredict_s = 1'b0;
        end else if (is_ctrl_s) begin
            mispredict_s = (pred_taken_s != e_taken_i) || target_miss_s;
        end else begin
            mispredict_s = pred_taken_s;
        end
        pop_s    = e_accept_s && head_hit_s;
        // A record offered while full still fits when the head retires in the same cycle
        push_s   = f_valid_i && idle_s && (!full_s || pop_s);
        pht_we_s = e_accept_s && is_branch_s;
        btb_we_s = e_accept_s && is_ctrl_s && target_miss_s;
    end

    assign f_ready_o = idle_s && !full_s && !reset_i;

    // Next-state logic: a mispredict costs exactly one flush cycle
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE:    state_n_s = mispredict_s ? FLUSH : IDLE;
            FLUSH:   state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Queue storage; a push coinciding with a mispredict is dropped
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc_r[i]     <= 32'd0;
                q_taken_r[i]  <= 1'b0;
                q_target_r[i] <= 32'd0;
                q_pht_r[i]    <= {NUM_GHR_BITS{1'b0}};
            end
        end else if (push_s && !mispredict_s) begin
            q_pc_r[wptr_r]     <= f_pc_i;
            q_taken_r[wptr_r]  <= f_taken_i;
            q_target_r[wptr_r] <= f_target_i;
            q_pht_r[wptr_r]    <= f_phtaddr_i;
        end
    end

    // Queue pointers and occupancy; a mispredict empties the queue
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (mispredict_s) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end

    // Registered single-cycle update pulses; every field reads zero when not active
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            BTBwe_o           <= 1'b0;
            BTBwriteaddress_o <= {BTB_IDX_W{1'b0}};
            BTBwritedata_o    <= 32'd0;
            PHTwe_o           <= 1'b0;
            PHTincrement_o    <= 1'b0;
            PHTwriteaddress_o <= {NUM_GHR_BITS{1'b0}};
            GHRreset_o        <= 1'b0;
            mispredict_o      <= 1'b0;
            redirect_pc_o     <= 32'd0;
        end else begin
            BTBwe_o           <= btb_we_s;
            BTBwriteaddress_o <= btb_we_s ? e_pc_i[BTB_IDX_W+1:2] : {BTB_IDX_W{1'b0}};
            BTBwritedata_o    <= btb_we_s ? e_target_i : 32'd0;
            PHTwe_o           <= pht_we_s;
            PHTincrement_o    <= pht_we_s && e_taken_i;
            PHTwriteaddress_o <= pht_we_s ? pred_pht_s : {NUM_GHR_BITS{1'b0}};
            GHRreset_o        <= mispredict_s;
            mispredict_o      <= mispredict_s;
            redirect_pc_o     <= mispredict_s ? (e_taken_i ? e_target_i : pc_plus4_s) : 32'd0;
        end
    end

`ifdef BRANCH_STATS_EN
    // Wrapping counters of resolved branches and mispredicts
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            branch_count_o     <= 32'd0;
            mispredict_count_o <= 32'd0;
        end else begin
            if (pht_we_s) begin
                branch_count_o <= branch_count_o + 32'd1;
            end
            if (mispredict_s) begin
                mispredict_count_o <= mispredict_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Self-checking bench for ucsbece154b_branch_resolve: directed scenarios plus
// randomized traffic, compared against a queue-based reference model.
module tb_ucsbece154b_branch_resolve;

    localparam int NG = 5;
    localparam int QD = 4;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          f_valid_i;
    logic [31:0]   f_pc_i;
    logic          f_taken_i;
    logic [31:0]   f_target_i;
    logic [NG-1:0] f_phtaddr_i;
    logic          f_ready_o;
    logic          e_valid_i;
    logic [6:0]    e_op_i;
    logic [31:0]   e_pc_i;
    logic          e_taken_i;
    logic [31:0]   e_target_i;
    logic          BTBwe_o;
    logic [4:0]    BTBwriteaddress_o;
    logic [31:0]   BTBwritedata_o;
    logic          PHTwe_o;
    logic          PHTincrement_o;
    logic [NG-1:0] PHTwriteaddress_o;
    logic          GHRreset_o;
    logic          mispredict_o;
    logic [31:0]   redirect_pc_o;
`ifdef BRANCH_STATS_EN
    logic [31:0]   branch_count_o;
    logic [31:0]   mispredict_count_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0]   pc;
        logic          taken;
        logic [31:0]   target;
        logic [NG-1:0] pht;
    } rec_t;

    rec_t        mq[$];
    bit          m_flush = 1'b0;
    logic [31:0] m_br_cnt = 32'd0;
    logic [31:0] m_mis_cnt = 32'd0;

    ucsbece154b_branch_resolve #(
        .NUM_BTB_ENTRIES(32),
        .NUM_GHR_BITS(NG),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk),
        .reset_i(reset_i),
        .f_valid_i(f_valid_i),
        .f_pc_i(f_pc_i),
        .f_taken_i(f_taken_i),
        .f_target_i(f_target_i),
        .f_phtaddr_i(f_phtaddr_i),
        .f_ready_o(f_ready_o),
        .e_valid_i(e_valid_i),
        .e_op_i(e_op_i),
        .e_pc_i(e_pc_i),
        .e_taken_i(e_taken_i),
        .e_target_i(e_target_i),
        .BTBwe_o(BTBwe_o),
        .BTBwriteaddress_o(BTBwriteaddress_o),
        .BTBwritedata_o(BTBwritedata_o),
        .PHTwe_o(PHTwe_o),
        .PHTincrement_o(PHTincrement_o),
        .PHTwriteaddress_o(PHTwriteaddress_o),
        .GHRreset_o(GHRreset_o),
        .mispredict_o(mispredict_o),
        .redirect_pc_o(redirect_pc_o)
`ifdef BRANCH_STATS_EN
        ,
        .branch_count_o(branch_count_o),
        .mispredict_count_o(mispredict_count_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_btbwe"},   32'(BTBwe_o), 32'd0);
        check({pfx, "_btbaddr"}, 32'(BTBwriteaddress_o), 32'd0);
        check({pfx, "_btbdata"}, BTBwritedata_o, 32'd0);
        check({pfx, "_phtwe"},   32'(PHTwe_o), 32'd0);
        check({pfx, "_phtinc"},  32'(PHTincrement_o), 32'd0);
        check({pfx, "_phtaddr"}, 32'(PHTwriteaddress_o), 32'd0);
        check({pfx, "_ghrrst"},  32'(GHRreset_o), 32'd0);
        check({pfx, "_mispred"}, 32'(mispredict_o), 32'd0);
        check({pfx, "_redir"},   redirect_pc_o, 32'd0);
    endtask

    // Assert reset asynchronously, check cleared outputs, release, clear the model
    task automatic do_reset();
        reset_i   = 1'b1;
        f_valid_i = 1'b0;
        e_valid_i = 1'b0;
        #1;
        check("rst_ready", 32'(f_ready_o), 32'd0);
        check_all_zero("rst");
`ifdef BRANCH_STATS_EN
        check("rst_brcnt", branch_count_o, 32'd0);
        check("rst_miscnt", mispredict_count_o, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        mq.delete();
        m_flush   = 1'b0;
        m_br_cnt  = 32'd0;
        m_mis_cnt = 32'd0;
        #1;
        check("rel_ready", 32'(f_ready_o), 32'd1);
    endtask

    // One clock: drive inputs, check readiness, clock, check registered outputs, advance model
    task automatic step(input logic fv, input logic [31:0] fpc, input logic ft,
                        input logic [31:0] ftg, input logic [NG-1:0] fph,
                        input logic ev, input logic [6:0] op, input logic [31:0] epc,
                        input logic et, input logic [31:0] etg);
        rec_t        pred;
        rec_t        nrec;
        bit          hit, acc, ctrl, mis, pht_we, btb_we, pop, push;
        logic [31:0] pc4;
        f_valid_i   = fv;
        f_pc_i      = fpc;
        f_taken_i   = ft;
        f_target_i  = ftg;
        f_phtaddr_i = fph;
        e_valid_i   = ev;
        e_op_i      = op;
        e_pc_i      = epc;
        e_taken_i   = et;
        e_target_i  = etg;
        #1;
        check("ready", 32'(f_ready_o), 32'(!m_flush && (mq.size() < QD)));

        pc4 = epc + 32'd4;
        acc = ev && !m_flush;
        hit = 1'b0;
        if (mq.size() > 0) hit = (mq[0].pc == epc);
        if (hit) begin
            pred = mq[0];
        end else begin
            pred.pc = epc; pred.taken = 1'b0; pred.target = pc4; pred.pht = '0;
        end
        ctrl = (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
        mis  = 1'b0;
        if (acc) begin
            if (ctrl) mis = (pred.taken != et) || (et && (pred.target != etg));
            else      mis = pred.taken;
        end
        pht_we = acc && (op == OP_BR);
        btb_we = acc && ctrl && et && (pred.target != etg);
        pop    = acc && hit;
        push   = fv && !m_flush && ((mq.size() < QD) || pop);

        @(posedge clk);
        #1;
        check("btbwe",   32'(BTBwe_o), 32'(btb_we));
        check("btbaddr", 32'(BTBwriteaddress_o), btb_we ? 32'((epc >> 2) % 32) : 32'd0);
        check("btbdata", BTBwritedata_o, btb_we ? etg : 32'd0);
        check("phtwe",   32'(PHTwe_o), 32'(pht_we));
        check("phtinc",  32'(PHTincrement_o), 32'(pht_we && et));
        check("phtaddr", 32'(PHTwriteaddress_o), pht_we ? 32'(pred.pht) : 32'd0);
        check("ghrrst",  32'(GHRreset_o), 32'(mis));
        check("mispred", 32'(mispredict_o), 32'(mis));
        check("redir",   redirect_pc_o, mis ? (et ? etg : pc4) : 32'd0);
        if (pht_we) m_br_cnt = m_br_cnt + 32'd1;
        if (mis)    m_mis_cnt = m_mis_cnt + 32'd1;
`ifdef BRANCH_STATS_EN
        check("brcnt", branch_count_o, m_br_cnt);
        check("miscnt", mispredict_count_o, m_mis_cnt);
`endif
        if (mis) begin
            mq.delete();
            m_flush = 1'b1;
        end else begin
            m_flush = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                nrec.pc = fpc; nrec.taken = ft; nrec.target = ftg; nrec.pht = fph;
                mq.push_back(nrec);
            end
        end
        f_valid_i = 1'b0;
        e_valid_i = 1'b0;
    endtask

    logic [6:0] op_tbl [6];

    initial begin
        logic          fv, ft, ev, et;
        logic [31:0]   fpc, ftg, epc, etg;
        logic [NG-1:0] fph;
        logic [6:0]    op;

        op_tbl[0] = OP_BR; op_tbl[1] = OP_BR; op_tbl[2] = OP_JAL;
        op_tbl[3] = OP_JALR; op_tbl[4] = OP_ADD; op_tbl[5] = OP_LW;
        f_valid_i = 1'b0; f_pc_i = 32'd0; f_taken_i = 1'b0; f_target_i = 32'd0;
        f_phtaddr_i = '0; e_valid_i = 1'b0; e_op_i = 7'd0; e_pc_i = 32'd0;
        e_taken_i = 1'b0; e_target_i = 32'd0;

        do_reset();

        // Fill to capacity, fifth offer refused, then push+pop while full
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 32'h2000, NG'(i),
                 1'b0, OP_ADD, 32'd0, 1'b0, 32'd0);
        end
        check("r21_full", 32'(f_ready_o), 32'd0);
        step(1'b1, 32'h1010, 1'b1, 32'h2000, 5'd4, 1'b0, OP_ADD, 32'd0, 1'b0, 32'd0);
        step(1'b1, 32'h1040, 1'b1, 32'h2000, 5'd7, 1'b1, OP_JAL, 32'h1000, 1'b1, 32'h2000);
        check("r21_still_full", 32'(f_ready_o), 32'd0);
        step(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, OP_JAL, 32'h1004, 1'b1, 32'h2000);
        step(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, OP_JAL, 32'h1008, 1'b1, 32'h2000);
        step(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, OP_JAL, 32'h100C, 1'b1, 32'h2000);
        step(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, OP_JAL, 32'h1040, 1'b1, 32'h2000);
        check("r21_last_hit", 32'(mispredict_o), 32'd0);

        // Correctly predicted taken branch
        do_reset();
        step(1'b1, 32'h100, 1'b1, 32'h80, 5'd3, 1'b0, OP_ADD, 32'd0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, OP_BR, 32'h100, 1'b1, 32'h80);
        check("r22_phtwe", 32'(PHTwe_o), 32'd1);
        check("r22_phtinc", 32'(PHTincrement_o), 32'd1);
        check("r22_phtaddr", 32'(PHTwriteaddress_o), 32'd3);
        check("r22_mispred", 32'(mispredict_o), 32'd0);
        check("r22_btbwe", 32'(BTBwe_o), 32'd0);

        // jal mispredict; a same-cycle push is discarded by the flush
        step(1'b1, 32'h200, 1'b0, 32'h204, 5'd0, 1'b0, OP_ADD, 32'd0, 1'b0, 32'd0);
        step(1'b1, 32'h700, 1'b1, 32'h900, 5'd0, 1'b1, OP_JAL, 32'h200, 1'b1, 32'h400);
        check("r23_mispred", 32'(mispredict_o), 32'd1);
        check("r23_ghrrst", 32'(GHRreset_o), 32'd1);
        check("r23_redir", redirect_pc_o, 32'h400);
        check("r23_btbwe", 32'(BTBwe_o), 32'd1);
        check("r23_btbaddr", 32'(BTBwriteaddress_o), 32'd0);
        check("r23_btbdata", BTBwritedata_o, 32'h400);
        check("r23_flush_ready", 32'(f_ready_o), 32'd0);
`ifdef BRANCH_STATS_EN
        check("r26_brcnt", branch_count_o, 32'd1);
        check("r26_miscnt", mispredict_count_o, 32'd1);
`endif
        step(1'b1, 32'h900, 1'b0, 32'd0, 5'd0, 1'b1, OP_BR, 32'h999, 1'b1, 32'h40);
        check("r23_flush_ignored", 32'(PHTwe_o), 32'd0);
        step(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, OP_ADD, 32'h700, 1'b0, 32'd0);
        check("r23_queue_empty", 32'(mispredict_o), 32'd0);

        // Empty queue: non-control op, then not-taken branch with default prediction
        do_reset();
        step(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, OP_ADD, 32'h300, 1'b0, 32'd0);
        check_all_zero("r24_add");
        step(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, OP_BR, 32'h304, 1'b0, 32'h308);
        check("r24_phtwe", 32'(PHTwe_o), 32'd1);
        check("r24_phtinc", 32'(PHTincrement_o), 32'd0);
        check("r24_phtaddr", 32'(PHTwriteaddress_o), 32'd0);
        check("r24_mispred", 32'(mispredict_o), 32'd0);

        // Reset during FLUSH
        step(1'b1, 32'h500, 1'b0, 32'h504, 5'd2, 1'b0, OP_ADD, 32'd0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, OP_JAL, 32'h500, 1'b1, 32'h600);
        check("r25_mispred_pre", 32'(mispredict_o), 32'd1);
        do_reset();

        // Reset empties a non-empty queue
        step(1'b1, 32'h520, 1'b1, 32'h600, 5'd1, 1'b0, OP_ADD, 32'd0, 1'b0, 32'd0);
        do_reset();
        step(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, OP_ADD, 32'h520, 1'b0, 32'd0);
        check("rst_queue_empty", 32'(mispredict_o), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                fv  = 1'($urandom_range(0, 1));
                fpc = 32'h100 + 32'(4 * $urandom_range(0, 7));
                ft  = 1'($urandom_range(0, 1));
                ftg = 32'h800 + 32'(4 * $urandom_range(0, 3));
                fph = NG'($urandom_range(0, 31));
                ev  = ($urandom_range(0, 2) != 0);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0) epc = mq[0].pc;
                else epc = 32'h100 + 32'(4 * $urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) epc = 32'hFFFF_FFFC;
                op  = op_tbl[$urandom_range(0, 5)];
                et  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 4) == 0) etg = epc + 32'd4;
                else etg = 32'h800 + 32'(4 * $urandom_range(0, 3));
                step(fv, fpc, ft, ftg, fph, ev, op, epc, et, etg);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
